// File: rtl/coarse_gain_ctrl_pkg.sv
// Shared constants for the coarse gain controller: FSM encodings, shift rail and target level.
package coarse_gain_ctrl_pkg;

  localparam logic [1:0] ST_ACQ    = 2'd0;
  localparam logic [1:0] ST_DECIDE = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  localparam logic [2:0] ADJ_MAX = 3'd7;

  // Upper edge of the target band for the shifted peak; the lower edge is a quarter of this.
  function automatic int top_level(input int width, input int headroom_bits);
    return 1 << (width - 1 - headroom_bits);
  endfunction

endpackage

// File: rtl/coarse_gain_ctrl_if.sv
// Sample stream into the gain controller: signed pre-shift data plus its strobe.
interface coarse_gain_ctrl_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] data;
  logic                    valid;

  modport master (output data, valid);
  modport slave  (input  data, valid);
endinterface

// File: rtl/coarse_gain_ctrl_peak_abs_tracker.sv
// Clamped |x|, running peak over valid samples and sticky post-shift overflow flag; clear wins over update.
module peak_abs_tracker #(
  parameter int WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clr_i,
  input  logic                    vld_i,
  input  logic signed [WIDTH-1:0] data_i,
  input  logic [2:0]              adj_i,
  output logic [WIDTH-2:0]        peak_o,
  output logic                    ovf_o
);

  logic [WIDTH-1:0]  neg;
  logic [WIDTH-2:0]  mag;
  logic [WIDTH+6:0]  shifted;
  logic              ovf_hit;
  logic [WIDTH-2:0]  peak_q, peak_d;
  logic              ovf_q, ovf_d;

  assign neg = -data_i;

  // The most negative code has no positive twin, so it saturates to full scale.
  always_comb begin
    mag = data_i[WIDTH-2:0];
    if (data_i[WIDTH-1]) begin
      if (data_i[WIDTH-2:0] == '0) mag = '1;
      else                         mag = neg[WIDTH-2:0];
    end
  end

  assign shifted = {8'd0, mag} << adj_i;
  assign ovf_hit = |shifted[WIDTH+6:WIDTH-1];

  always_comb begin
    peak_d = peak_q;
    ovf_d  = ovf_q;
    if (clr_i) begin
      peak_d = '0;
      ovf_d  = 1'b0;
    end else if (vld_i) begin
      if (mag > peak_q) peak_d = mag;
      if (ovf_hit)      ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      peak_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      peak_q <= peak_d;
      ovf_q  <= ovf_d;
    end
  end

  assign peak_o = peak_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/coarse_gain_ctrl.sv
// Windowed-peak AGC stepping the 3-bit coarse shift by at most one per window, with settle gap and manual override.
module coarse_gain_ctrl
  import coarse_gain_ctrl_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int WIN_LOG2      = 10,
  parameter int SETTLE        = 16,
  parameter int HEADROOM_BITS = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  coarse_gain_ctrl_if.slave smp_if,
  input  logic              auto_en_i,
  input  logic [2:0]        manual_adj_i,
  output logic [2:0]        adj_o,
  output logic              adj_change_o,
  output logic [WIDTH-2:0]  peak_o,
  output logic              overflow_o
);

  localparam int               SW          = $clog2(SETTLE + 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [WIDTH+6:0] TOP         = (WIDTH + 7)'(top_level(WIDTH, HEADROOM_BITS));
  localparam logic [WIDTH+6:0] TOP_QTR     = TOP >> 2;

  logic [1:0]          state_q, state_d;
  logic [2:0]          adj_q, adj_d;
  logic                adj_change_q;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [SW-1:0]       scnt_q, scnt_d;
  logic [WIDTH-2:0]    peak_q, peak_d;
  logic [WIDTH-2:0]    run_peak;
  logic [WIDTH+6:0]    m;
  logic                trk_clr, trk_vld;

  peak_abs_tracker #(.WIDTH(WIDTH)) u_trk (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (trk_clr),
    .vld_i  (trk_vld),
    .data_i (smp_if.data),
    .adj_i  (adj_q),
    .peak_o (run_peak),
    .ovf_o  (overflow_o)
  );

  assign m = {8'd0, run_peak} << adj_q;

  always_comb begin
    state_d = state_q;
    adj_d   = adj_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    peak_d  = peak_q;
    trk_clr = 1'b0;
    trk_vld = 1'b0;
    if (!auto_en_i) begin
      adj_d   = manual_adj_i;
      state_d = ST_ACQ;
      cnt_d   = '0;
      scnt_d  = '0;
      trk_clr = 1'b1;
    end else begin
      case (state_q)
        ST_ACQ: begin
          trk_vld = smp_if.valid;
          if (smp_if.valid) begin
            if (cnt_q == '1) begin
              cnt_d   = '0;
              state_d = ST_DECIDE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_DECIDE: begin
          peak_d  = run_peak;
          trk_clr = 1'b1;
          cnt_d   = '0;
          if (m >= TOP && adj_q != 3'd0)          adj_d = adj_q - 3'd1;
          else if (m < TOP_QTR && adj_q != ADJ_MAX) adj_d = adj_q + 3'd1;
          state_d = (adj_d != adj_q) ? ST_SETTLE : ST_ACQ;
        end
        ST_SETTLE: begin
          if (smp_if.valid) begin
            if (scnt_q == SETTLE_LAST) begin
              scnt_d  = '0;
              state_d = ST_ACQ;
            end else begin
              scnt_d = scnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_ACQ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= ST_ACQ;
      adj_q        <= 3'd0;
      adj_change_q <= 1'b0;
      cnt_q        <= '0;
      scnt_q       <= '0;
      peak_q       <= '0;
    end else begin
      state_q      <= state_d;
      adj_q        <= adj_d;
      adj_change_q <= (adj_d != adj_q);
      cnt_q        <= cnt_d;
      scnt_q       <= scnt_d;
      peak_q       <= peak_d;
    end
  end

  assign adj_o        = adj_q;
  assign adj_change_o = adj_change_q;
  assign peak_o       = peak_q;

endmodule

// File: tb/tb_coarse_gain_ctrl.sv
// Directed scenarios plus random soak, every cycle compared against a window/queue-based reference model.
module tb_coarse_gain_ctrl;

  localparam int WIDTH = 16;
  localparam int WIN   = 16;
  localparam int SETL  = 4;
  localparam int TOP   = 16384;
  localparam int TOPQ  = 4096;

  logic        clk = 1'b0;
  logic        rstn;
  logic        auto_en;
  logic [2:0]  manual_adj;
  logic [2:0]  adj;
  logic        adj_change;
  logic [14:0] peak;
  logic        overflow;
  int          din;

  coarse_gain_ctrl_if #(.WIDTH(WIDTH)) smp_if ();

  coarse_gain_ctrl #(
    .WIDTH(WIDTH), .WIN_LOG2(4), .SETTLE(SETL), .HEADROOM_BITS(1)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .smp_if       (smp_if),
    .auto_en_i    (auto_en),
    .manual_adj_i (manual_adj),
    .adj_o        (adj),
    .adj_change_o (adj_change),
    .peak_o       (peak),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the window is literally the list of accepted samples.
  int m_adj, m_chg, m_peak, m_phase, m_sc;
  int m_win[$];

  function automatic int absc(input int x);
    if (x == -32768) return 32767;
    return (x < 0) ? -x : x;
  endfunction

  function automatic int exp_ovf();
    foreach (m_win[i])
      if (absc(m_win[i]) * (1 << m_adj) >= 32768) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int pk, mm, nadj;
    if (!rstn) begin
      m_adj = 0; m_chg = 0; m_peak = 0; m_phase = 0; m_sc = 0;
      m_win.delete();
    end else if (!auto_en) begin
      m_chg = (int'(manual_adj) != m_adj) ? 1 : 0;
      m_adj = int'(manual_adj);
      m_phase = 0; m_sc = 0;
      m_win.delete();
    end else begin
      m_chg = 0;
      case (m_phase)
        0: if (smp_if.valid) begin
          m_win.push_back(din);
          if (m_win.size() == WIN) m_phase = 1;
        end
        1: begin
          pk = 0;
          foreach (m_win[i]) if (absc(m_win[i]) > pk) pk = absc(m_win[i]);
          m_peak = pk;
          mm = pk * (1 << m_adj);
          nadj = m_adj;
          if (mm >= TOP && m_adj > 0) nadj = m_adj - 1;
          else if (mm < TOPQ && m_adj < 7) nadj = m_adj + 1;
          m_chg = (nadj != m_adj) ? 1 : 0;
          m_adj = nadj;
          m_win.delete();
          m_phase = m_chg ? 2 : 0;
        end
        default: if (smp_if.valid) begin
          m_sc++;
          if (m_sc == SETL) begin m_sc = 0; m_phase = 0; end
        end
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("adj_o", 32'(adj), m_adj);
    chk("adj_change_o", 32'(adj_change), m_chg);
    chk("peak_o", 32'(peak), m_peak);
    chk("overflow_o", 32'(overflow), exp_ovf());
  endtask

  task automatic drive(input int d, input logic v);
    din = d;
    smp_if.data = 16'(d);
    smp_if.valid = v;
  endtask

  int pulses, nv;
  logic seen_ovf;

  initial begin
    m_adj = 0; m_chg = 0; m_peak = 0; m_phase = 0; m_sc = 0;
    rstn = 1'b0; auto_en = 1'b1; manual_adj = 3'd0;
    drive(0, 1'b0);

    // 1: reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      auto_en = 1'($urandom); manual_adj = 3'($urandom);
      drive(int'($urandom_range(0, 65535)) - 32768, 1'($urandom));
      cyc();
      chk("rst_adj", 32'(adj), 0);
      chk("rst_pulse", 32'(adj_change), 0);
      chk("rst_peak", 32'(peak), 0);
      chk("rst_ovf", 32'(overflow), 0);
    end

    // 2: small constant input ramps the shift up to 6
    rstn = 1'b1; auto_en = 1'b1; manual_adj = 3'd0;
    drive(100, 1'b1);
    pulses = 0;
    for (int i = 0; i < 170; i++) begin cyc(); if (adj_change) pulses++; end
    chk("s2_adj", 32'(adj), 6);
    chk("s2_pulses", pulses, 6);
    chk("s2_peak", 32'(peak), 100);

    // 3: large negative input steps back down to 2
    drive(-3000, 1'b1);
    pulses = 0; seen_ovf = 1'b0;
    for (int i = 0; i < 130; i++) begin
      cyc();
      if (adj_change) pulses++;
      if (i < 18 && overflow) seen_ovf = 1'b1;
    end
    chk("s3_ovf_seen", 32'(seen_ovf), 1);
    chk("s3_adj", 32'(adj), 2);
    chk("s3_pulses", pulses, 4);
    chk("s3_ovf_clear", 32'(overflow), 0);

    // 4: full-scale negative at the bottom rail
    auto_en = 1'b0; manual_adj = 3'd0;
    cyc(); cyc();
    auto_en = 1'b1;
    drive(-32768, 1'b1);
    for (int i = 0; i < 20; i++) cyc();
    chk("s4_peak", 32'(peak), 32767);
    chk("s4_adj", 32'(adj), 0);
    chk("s4_ovf", 32'(overflow), 0);

    // 5: manual override mid-window, then a fresh automatic window
    for (int i = 0; i < 5; i++) cyc();
    auto_en = 1'b0; manual_adj = 3'd5;
    cyc();
    chk("s5_man_adj", 32'(adj), 5);
    chk("s5_man_pulse", 32'(adj_change), 1);
    cyc();
    chk("s5_man_nopulse", 32'(adj_change), 0);
    auto_en = 1'b1;
    drive(3000, 1'b1);
    for (int i = 0; i < WIN; i++) cyc();
    chk("s5_hold_window", 32'(adj), 5);
    cyc();
    chk("s5_decide_adj", 32'(adj), 4);
    chk("s5_decide_pulse", 32'(adj_change), 1);

    // 6: reset pulse during settle, then a full fresh window at 50% valid
    drive(3000, 1'($urandom));
    cyc();
    rstn = 1'b0;
    cyc();
    chk("s6_rst_adj", 32'(adj), 0);
    rstn = 1'b1;
    nv = 0;
    for (int i = 0; i < 400 && nv < WIN; i++) begin
      drive(3000, 1'($urandom));
      cyc();
      if (smp_if.valid) nv++;
    end
    chk("s6_valid_count", nv, WIN);
    chk("s6_before_decide", 32'(adj), 0);
    drive(3000, 1'b0);
    cyc();
    chk("s6_after_decide", 32'(adj), 1);
    chk("s6_pulse", 32'(adj_change), 1);

    // 7: random soak
    for (int i = 0; i < 3000; i++) begin
      drive((int'($urandom_range(0, 65535)) - 32768) / (1 << $urandom_range(0, 12)),
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      manual_adj = 3'($urandom);
      rstn = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
